// File: rtl/data_sram_responder_pkg.sv
// rtl/data_sram_responder_pkg.sv - shared size encodings, defaults and alignment helper for the data SRAM responder
package data_sram_responder_pkg;

    localparam int DSR_RESP_LAT_DEF = 1;
    localparam int DSR_MAX_OUT_DEF  = 2;
    localparam int DSR_RESP_W       = 32;
    // Wide enough to hold the largest legal outstanding count (7)
    localparam int DSR_CNT_W        = 3;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10,
        SIZE_RSVD = 2'b11
    } dsr_size_e;

    // Reserved size 11 is reported as misaligned so it never touches the RAM
    function automatic logic dsr_misaligned(input logic [1:0] size, input logic [1:0] lsb);
        logic mis;
        mis = 1'b1;
        case (dsr_size_e'(size))
            SIZE_BYTE: mis = 1'b0;
            SIZE_HALF: mis = lsb[0];
            SIZE_WORD: mis = (lsb != 2'b00);
            default:   mis = 1'b1;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/data_sram_responder_resp_pipe.sv
// rtl/data_sram_responder_resp_pipe.sv - RESP_LAT-deep response tracking pipeline (dsr_resp_pipe)
module dsr_resp_pipe
    import data_sram_responder_pkg::*;
#(
    parameter int RESP_LAT = DSR_RESP_LAT_DEF
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  in_valid,
    input  logic                  in_wr,
    input  logic                  in_err,
    input  logic [DSR_RESP_W-1:0] ram_rdata,
    output logic                  out_valid,
    output logic [DSR_RESP_W-1:0] out_rdata,
    output logic                  out_err
);

    // Stage i holds the request accepted i+1 cycles ago
    logic [RESP_LAT-1:0]   v_q;
    logic [RESP_LAT-1:0]   wr_q;
    logic [RESP_LAT-1:0]   err_q;
    logic [DSR_RESP_W-1:0] word;

    // Shift the {valid, wr, err} tags one stage per cycle; reset drops everything in flight
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            v_q   <= '0;
            wr_q  <= '0;
            err_q <= '0;
        end else begin
            v_q[0]   <= in_valid;
            wr_q[0]  <= in_wr;
            err_q[0] <= in_err;
            for (int i = 1; i < RESP_LAT; i++) begin
                v_q[i]   <= v_q[i-1];
                wr_q[i]  <= wr_q[i-1];
                err_q[i] <= err_q[i-1];
            end
        end
    end

    generate
        if (RESP_LAT == 1) begin : g_direct
            // Read data arrives in the same cycle the response is due
            assign word = ram_rdata;
        end else begin : g_carry
            logic [DSR_RESP_W-1:0] d_q [RESP_LAT-1];

            // Capture SRAM data one cycle after the access and carry it alongside its tag
            always_ff @(posedge clk) begin
                d_q[0] <= ram_rdata;
                for (int i = 1; i < RESP_LAT - 1; i++) begin
                    d_q[i] <= d_q[i-1];
                end
            end

            assign word = d_q[RESP_LAT-2];
        end
    endgenerate

    assign out_valid = v_q[RESP_LAT-1];
    assign out_err   = v_q[RESP_LAT-1] & err_q[RESP_LAT-1];
    // Stores and misaligned accesses return zero; idle cycles return zero
    assign out_rdata = (v_q[RESP_LAT-1] && !wr_q[RESP_LAT-1] && !err_q[RESP_LAT-1]) ? word : '0;

endmodule

// File: rtl/data_sram_responder.sv
// rtl/data_sram_responder.sv - data SRAM request/response bridge; optional DSR_STALL_INJECT_EN adds LFSR stalls
module data_sram_responder
    import data_sram_responder_pkg::*;
#(
    parameter int RESP_LAT = DSR_RESP_LAT_DEF,
    parameter int MAX_OUT  = DSR_MAX_OUT_DEF
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  data_sram_req,
    input  logic                  data_sram_wr,
    input  logic [1:0]            data_sram_size,
    input  logic [31:0]           data_sram_addr,
    input  logic [3:0]            data_sram_wstrb,
    input  logic [31:0]           data_sram_wdata,
    output logic                  data_sram_addr_ok,
    output logic                  data_sram_data_ok,
    output logic [DSR_RESP_W-1:0] data_sram_rdata,
    output logic                  data_sram_err,
    output logic                  ram_en,
    output logic [3:0]            ram_we,
    output logic [29:0]           ram_addr,
    output logic [31:0]           ram_wdata,
    input  logic [31:0]           ram_rdata
);

    logic [DSR_CNT_W-1:0] outstanding;
    logic                 handshake;
    logic                 misaligned;
    logic                 stall;

`ifdef DSR_STALL_INJECT_EN
    logic [3:0] lfsr;

    // x^4+x^3+1 LFSR, free-running, used to inject pseudo-random accept stalls
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lfsr <= 4'b1001;
        end else begin
            lfsr <= {lfsr[2:0], lfsr[3] ^ lfsr[2]};
        end
    end

    assign stall = lfsr[0];
`else
    assign stall = 1'b0;
`endif

    // Accept depends only on the registered count, never on a same-cycle response
    assign data_sram_addr_ok = resetn && data_sram_req && !stall
                             && (outstanding < DSR_CNT_W'(MAX_OUT));
    assign handshake  = data_sram_req && data_sram_addr_ok;
    assign misaligned = dsr_misaligned(data_sram_size, data_sram_addr[1:0]);

    assign ram_en    = handshake;
    assign ram_we    = (handshake && data_sram_wr && !misaligned) ? data_sram_wstrb : 4'b0000;
    assign ram_addr  = data_sram_addr[31:2];
    assign ram_wdata = data_sram_wdata;

    // Count accepted-but-unanswered requests; simultaneous accept and answer cancel
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            outstanding <= '0;
        end else begin
            case ({handshake, data_sram_data_ok})
                2'b10:   outstanding <= outstanding + DSR_CNT_W'(1);
                2'b01:   outstanding <= outstanding - DSR_CNT_W'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    dsr_resp_pipe #(
        .RESP_LAT (RESP_LAT)
    ) u_resp_pipe (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (handshake),
        .in_wr     (data_sram_wr),
        .in_err    (misaligned),
        .ram_rdata (ram_rdata),
        .out_valid (data_sram_data_ok),
        .out_rdata (data_sram_rdata),
        .out_err   (data_sram_err)
    );

endmodule

// File: tb/tb_data_sram_responder.sv
// tb/tb_data_sram_responder.sv - scoreboard bench for data_sram_responder against a word-array reference model
module tb_data_sram_responder;

    localparam int LAT  = 3;
    localparam int MAXO = 2;

    logic        clk = 1'b0;
    logic        resetn;
    logic        data_sram_req;
    logic        data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [31:0] data_sram_addr;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_wdata;
    logic        data_sram_addr_ok;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic        data_sram_err;
    logic        ram_en;
    logic [3:0]  ram_we;
    logic [29:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    data_sram_responder #(
        .RESP_LAT (LAT),
        .MAX_OUT  (MAXO)
    ) dut (
        .clk               (clk),
        .resetn            (resetn),
        .data_sram_req     (data_sram_req),
        .data_sram_wr      (data_sram_wr),
        .data_sram_size    (data_sram_size),
        .data_sram_addr    (data_sram_addr),
        .data_sram_wstrb   (data_sram_wstrb),
        .data_sram_wdata   (data_sram_wdata),
        .data_sram_addr_ok (data_sram_addr_ok),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .data_sram_err     (data_sram_err),
        .ram_en            (ram_en),
        .ram_we            (ram_we),
        .ram_addr          (ram_addr),
        .ram_wdata         (ram_wdata),
        .ram_rdata         (ram_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          due;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    logic [31:0] sram    [256];
    logic [31:0] ref_mem [256];
    int          cyc   = 0;
    int          nvec  = 0;
    int          nfail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous SRAM environment model
    always @(posedge clk) begin
        if (ram_en) begin
            ram_rdata <= sram[ram_addr[7:0]];
            for (int b = 0; b < 4; b++) begin
                if (ram_we[b]) sram[ram_addr[7:0]][8*b +: 8] <= ram_wdata[8*b +: 8];
            end
        end
    end

`ifdef DSR_STALL_INJECT_EN
    logic [3:0] tb_lfsr;
    always @(posedge clk or negedge resetn) begin
        if (!resetn) tb_lfsr <= 4'b1001;
        else         tb_lfsr <= {tb_lfsr[2:0], tb_lfsr[3] ^ tb_lfsr[2]};
    end
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pop and compare whenever the DUT presents a response
    always @(negedge clk) begin
        if (data_sram_data_ok) begin
            if (q.size() == 0) begin
                nvec++;
                nfail++;
                $display("FAIL unexpected_data_ok: got data_ok=1 expected no response (cycle %0d)", cyc);
            end else begin
                mon_e = q.pop_front();
                chk("resp_cycle", cyc, mon_e.due);
                chk("resp_rdata", data_sram_rdata, mon_e.rdata);
                chk("resp_err", {31'b0, data_sram_err}, {31'b0, mon_e.err});
            end
        end else begin
            chk("idle_zero", {data_sram_rdata[30:0], data_sram_err}, 32'h0);
        end
        if (q.size() > 0 && q[0].due < cyc) begin
            nvec++;
            nfail++;
            $display("FAIL missed_resp: got no data_ok expected one at cycle %0d (cycle %0d)", q[0].due, cyc);
            void'(q.pop_front());
        end
    end

    function automatic logic ref_mis(input logic [1:0] size, input logic [31:0] a);
        return (size == 2'd1 && a[0]) || (size == 2'd2 && a[1:0] != 2'd0) || (size == 2'd3);
    endfunction

    // Hold one request until accepted, checking accept and RAM-side outputs every cycle
    task automatic issue(input logic wr, input logic [1:0] size, input logic [31:0] a,
                         input logic [3:0] st, input logic [31:0] wd);
        int   tries = 0;
        bit   done  = 0;
        logic exp_ok;
        logic mis;
        exp_t e;
        while (!done) begin
            @(posedge clk);
            #1;
            data_sram_req   = 1'b1;
            data_sram_wr    = wr;
            data_sram_size  = size;
            data_sram_addr  = a;
            data_sram_wstrb = st;
            data_sram_wdata = wd;
            #2;
            exp_ok = (q.size() < MAXO);
`ifdef DSR_STALL_INJECT_EN
            exp_ok = exp_ok && !tb_lfsr[0];
`endif
            chk("addr_ok", {31'b0, data_sram_addr_ok}, {31'b0, exp_ok});
            if (exp_ok) begin
                mis = ref_mis(size, a);
                chk("ram_en", {31'b0, ram_en}, 32'h1);
                chk("ram_we", {28'b0, ram_we}, {28'b0, (wr && !mis) ? st : 4'b0});
                chk("ram_addr", {2'b0, ram_addr}, {2'b0, a[31:2]});
                chk("ram_wdata", ram_wdata, wd);
                e.err   = mis;
                e.rdata = (wr || mis) ? 32'h0 : ref_mem[a[9:2]];
                e.due   = cyc + LAT;
                q.push_back(e);
                if (wr && !mis) begin
                    for (int b = 0; b < 4; b++)
                        if (st[b]) ref_mem[a[9:2]][8*b +: 8] = wd[8*b +: 8];
                end
                done = 1;
            end else begin
                chk("ram_en_stalled", {31'b0, ram_en}, 32'h0);
            end
            tries++;
            if (!done && tries > 50) begin
                nvec++;
                nfail++;
                $display("FAIL accept_timeout: got no addr_ok expected accept within 50 cycles");
                done = 1;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            data_sram_req = 1'b0;
            #2;
            chk("idle_addr_ok", {31'b0, data_sram_addr_ok}, 32'h0);
            chk("idle_ram_en", {31'b0, ram_en}, 32'h0);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            sram[i]    = $urandom;
            ref_mem[i] = sram[i];
        end
        sram[8'h40]    = 32'hDEADBEEF;
        ref_mem[8'h40] = 32'hDEADBEEF;

        resetn          = 1'b0;
        data_sram_req   = 1'b1;
        data_sram_wr    = 1'b0;
        data_sram_size  = 2'b10;
        data_sram_addr  = 32'h0;
        data_sram_wstrb = 4'h0;
        data_sram_wdata = 32'h0;
        #3;
        chk("rst_addr_ok", {31'b0, data_sram_addr_ok}, 32'h0);
        chk("rst_ram_en", {31'b0, ram_en}, 32'h0);
        chk("rst_ram_we", {28'b0, ram_we}, 32'h0);
        chk("rst_data_ok", {31'b0, data_sram_data_ok}, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        resetn        = 1'b1;
        data_sram_req = 1'b0;

        // Aligned load word, byte store into lane 3, reload, misaligned half load
        issue(1'b0, 2'b10, 32'h0000_0100, 4'h0, 32'h0);
        idle(LAT);
        issue(1'b1, 2'b00, 32'h0000_0103, 4'b1000, 32'h5A5A5A5A);
        issue(1'b0, 2'b10, 32'h0000_0100, 4'h0, 32'h0);
        issue(1'b0, 2'b01, 32'h0000_0101, 4'h0, 32'h0);
        idle(LAT + 1);
        chk("store_merge", ref_mem[8'h40], 32'h5AADBEEF);

        // Request held high: outstanding limit throttles accepts
        for (int i = 0; i < 6; i++)
            issue(1'b0, 2'b10, 32'h0000_0100 + 32'(4 * i), 4'h0, 32'h0);
        idle(LAT + 1);

        // Reset with requests in flight
        issue(1'b0, 2'b10, 32'h0000_0200, 4'h0, 32'h0);
        issue(1'b0, 2'b10, 32'h0000_0204, 4'h0, 32'h0);
        @(posedge clk);
        #1;
        resetn        = 1'b0;
        data_sram_req = 1'b1;
        #1;
        chk("midrst_data_ok", {31'b0, data_sram_data_ok}, 32'h0);
        chk("midrst_addr_ok", {31'b0, data_sram_addr_ok}, 32'h0);
        chk("midrst_ram_en", {31'b0, ram_en}, 32'h0);
        chk("midrst_count", {29'b0, dut.outstanding}, 32'h0);
        q.delete();
        repeat (2) @(posedge clk);
        #1;
        resetn        = 1'b1;
        data_sram_req = 1'b0;
        idle(LAT + 2);

        // Randomized traffic
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(3) == 0) idle(1);
            issue(1'($urandom_range(1)), 2'($urandom_range(3)), $urandom,
                  4'($urandom_range(15)), $urandom);
        end

        for (int n = 0; n < 50 && q.size() > 0; n++) idle(1);
        chk("drain", q.size(), 32'h0);
        idle(LAT + 2);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
